// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: FIFO of ALU commands {a,b,sel} feeding a registered ALU
// operand stage, with hold/flush control and res_valid tracking.
// Optional feature: define ALU_DIVZERO_CHK_EN to drop divide-by-zero
// commands at the queue head and pulse divz_err instead of issuing them.
module alu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_a,
    input  logic [7:0]                 in_b,
    input  logic [1:0]                 in_sel,
    input  logic                       hold,
    input  logic                       flush,
    output logic [7:0]                 alu_a,
    output logic [7:0]                 alu_b,
    output logic [1:0]                 alu_sel,
    output logic                       issue,
    output logic                       res_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       divz_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Entry layout: [17:10] a, [9:2] b, [1:0] sel
    logic [17:0]   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [17:0]   head;
    logic          do_push;
    logic          do_pop;
    logic          head_divz;

    assign in_ready = (count < FULL);
    assign head     = mem[rptr];

    // Push/pop qualification; flush overrides both
    always_comb begin
        do_push = in_valid && in_ready && !flush;
        do_pop  = (count != '0) && !hold && !flush;
    end

`ifdef ALU_DIVZERO_CHK_EN
    assign head_divz = (head[1:0] == 2'b11) && (head[9:2] == 8'd0);
`else
    assign head_divz = 1'b0;
`endif

    // Command storage; no reset needed since pointers/count gate all reads
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= {in_a, in_b, in_sel};
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Issue stage: register popped head onto ALU operands, track result valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            issue     <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= issue;
            issue     <= do_pop && !head_divz;
            if (do_pop && !head_divz) begin
                alu_a   <= head[17:10];
                alu_b   <= head[9:2];
                alu_sel <= head[1:0];
            end
        end
    end

`ifdef ALU_DIVZERO_CHK_EN
    // One-cycle pulse when a divide-by-zero head entry is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divz_err <= 1'b0;
        end else begin
            divz_err <= do_pop && head_divz;
        end
    end
`else
    assign divz_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed self-checking bench for alu_cmd_queue (DEPTH=4).
module tb_alu_cmd_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [1:0]  in_sel;
    logic        hold;
    logic        flush;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [1:0]  alu_sel;
    logic        issue;
    logic        res_valid;
    logic [2:0]  count;
    logic        divz_err;
    logic [15:0] alu_out;

    int n_cmp = 0;
    int n_bad = 0;

    alu_cmd_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .hold(hold), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .issue(issue),
        .res_valid(res_valid), .count(count), .divz_err(divz_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 1-cycle ALU result register fed by the DUT operand outputs
    always @(posedge clk) begin
        case (alu_sel)
            2'b00:   alu_out <= {8'd0, alu_a} + {8'd0, alu_b};
            2'b01:   alu_out <= {8'd0, alu_a} - {8'd0, alu_b};
            2'b10:   alu_out <= {8'd0, alu_a} * {8'd0, alu_b};
            default: alu_out <= (alu_b == 8'd0) ? 16'hFFFF : {8'd0, alu_a / alu_b};
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        in_valid = 1'b1; in_a = a; in_b = b; in_sel = s;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_sel = 0; hold = 0; flush = 0;
        step(); step();
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if ({issue, res_valid, divz_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b exp=000", {issue, res_valid, divz_err}); end
        n_cmp++; if ({alu_a, alu_b, alu_sel} !== 18'd0) begin n_bad++; $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_sel}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        push(8'd5, 8'd3, 2'b00);
        n_cmp++; if (issue !== 1'b0) begin n_bad++; $display("FAIL basic_no_bypass got=%b exp=0", issue); end
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL basic_count got=%0d exp=1", count); end
        step();
        n_cmp++; if ({issue, alu_a, alu_b, alu_sel} !== {1'b1, 8'd5, 8'd3, 2'b00}) begin n_bad++; $display("FAIL basic_issue got=%b/%0d/%0d/%0d exp=1/5/3/0", issue, alu_a, alu_b, alu_sel); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL basic_res_early got=%b exp=0", res_valid); end
        step();
        n_cmp++; if ({res_valid, issue} !== 2'b10) begin n_bad++; $display("FAIL basic_res_valid got=%b exp=10", {res_valid, issue}); end
        n_cmp++; if (alu_out !== 16'd8) begin n_bad++; $display("FAIL basic_alu_out got=%0d exp=8", alu_out); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL basic_count_empty got=%0d exp=0", count); end
    endtask

    task automatic test_hold_order();
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        logic [1:0] es [4];
        ea = '{8'd1, 8'd3, 8'd6, 8'd8};
        eb = '{8'd2, 8'd4, 8'd7, 8'd2};
        es = '{2'b00, 2'b01, 2'b10, 2'b11};
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push(ea[i], eb[i], es[i]);
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL hold_full_count got=%0d exp=4", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (issue !== 1'b0) begin n_bad++; $display("FAIL hold_no_issue got=%b exp=0", issue); end
        push(8'hAA, 8'hBB, 2'b00);
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL hold_fifth_ignored got=%0d exp=4", count); end
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if ({issue, alu_a, alu_b, alu_sel} !== {1'b1, ea[i], eb[i], es[i]}) begin n_bad++; $display("FAIL hold_order_%0d got=%b/%0d/%0d/%0d exp=1/%0d/%0d/%0d", i, issue, alu_a, alu_b, alu_sel, ea[i], eb[i], es[i]); end
        end
        step();
        n_cmp++; if ({issue, count} !== {1'b0, 3'd0}) begin n_bad++; $display("FAIL hold_drained got=%b/%0d exp=0/0", issue, count); end
    endtask

    task automatic test_full_pop();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(10 + i), 8'd1, 2'b00);
        hold = 1'b0; in_valid = 1'b1; in_a = 8'hEE; in_b = 8'h01; in_sel = 2'b00;
        step();
        in_valid = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL fullpop_count got=%0d exp=3", count); end
        n_cmp++; if ({issue, alu_a} !== {1'b1, 8'd10}) begin n_bad++; $display("FAIL fullpop_issue got=%b/%0d exp=1/10", issue, alu_a); end
        for (int i = 1; i < 4; i++) begin
            step();
            n_cmp++; if ({issue, alu_a} !== {1'b1, 8'(10 + i)}) begin n_bad++; $display("FAIL fullpop_drain_%0d got=%b/%0d exp=1/%0d", i, issue, alu_a, 10 + i); end
        end
        step();
        n_cmp++; if ({issue, count} !== {1'b0, 3'd0}) begin n_bad++; $display("FAIL fullpop_absent got=%b/%0d exp=0/0", issue, count); end
    endtask

    task automatic test_flush();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) push(8'(20 + i), 8'd1, 2'b00);
        hold = 1'b0; flush = 1'b1; in_valid = 1'b1; in_a = 8'h77; in_b = 8'h01; in_sel = 2'b00;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if ({issue, count} !== {1'b0, 3'd0}) begin n_bad++; $display("FAIL flush_clear got=%b/%0d exp=0/0", issue, count); end
        step();
        n_cmp++; if ({issue, count} !== {1'b0, 3'd0}) begin n_bad++; $display("FAIL flush_absent got=%b/%0d exp=0/0", issue, count); end
        // flush on the edge after an issue: res_valid still follows that issue
        push(8'd2, 8'd2, 2'b10);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if ({res_valid, issue, alu_out} !== {1'b1, 1'b0, 16'd4}) begin n_bad++; $display("FAIL flush_res_valid got=%b/%b/%0d exp=1/0/4", res_valid, issue, alu_out); end
    endtask

    task automatic test_divz();
        hold = 1'b1;
        push(8'd9, 8'd0, 2'b11);
        push(8'd9, 8'd3, 2'b11);
        hold = 1'b0;
        step();
`ifdef ALU_DIVZERO_CHK_EN
        n_cmp++; if ({divz_err, issue, count} !== {1'b1, 1'b0, 3'd1}) begin n_bad++; $display("FAIL divz_drop got=%b/%b/%0d exp=1/0/1", divz_err, issue, count); end
        step();
        n_cmp++; if ({divz_err, issue, alu_b} !== {1'b0, 1'b1, 8'd3}) begin n_bad++; $display("FAIL divz_next got=%b/%b/%0d exp=0/1/3", divz_err, issue, alu_b); end
        step();
        n_cmp++; if ({res_valid, issue, alu_out} !== {1'b1, 1'b0, 16'd3}) begin n_bad++; $display("FAIL divz_result got=%b/%b/%0d exp=1/0/3", res_valid, issue, alu_out); end
`else
        n_cmp++; if ({divz_err, issue, alu_b} !== {1'b0, 1'b1, 8'd0}) begin n_bad++; $display("FAIL divz_first got=%b/%b/%0d exp=0/1/0", divz_err, issue, alu_b); end
        step();
        n_cmp++; if ({divz_err, issue, alu_b} !== {1'b0, 1'b1, 8'd3}) begin n_bad++; $display("FAIL divz_second got=%b/%b/%0d exp=0/1/3", divz_err, issue, alu_b); end
        step();
        n_cmp++; if ({res_valid, issue, alu_out} !== {1'b1, 1'b0, 16'd3}) begin n_bad++; $display("FAIL divz_result got=%b/%b/%0d exp=1/0/3", res_valid, issue, alu_out); end
`endif
    endtask

    task automatic test_async_reset();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) push(8'(40 + i), 8'd5, 2'b01);
        hold = 1'b0;
        step();
        n_cmp++; if ({issue, count} !== {1'b1, 3'd2}) begin n_bad++; $display("FAIL arst_setup got=%b/%0d exp=1/2", issue, count); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({issue, res_valid, divz_err, count} !== {3'b000, 3'd0}) begin n_bad++; $display("FAIL arst_flags got=%b/%b/%b/%0d exp=0/0/0/0", issue, res_valid, divz_err, count); end
        n_cmp++; if ({alu_a, alu_b, alu_sel} !== 18'd0) begin n_bad++; $display("FAIL arst_alu got=%h exp=0", {alu_a, alu_b, alu_sel}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
        step();
        rst = 1'b0;
        step();
        n_cmp++; if ({issue, res_valid, count} !== {2'b00, 3'd0}) begin n_bad++; $display("FAIL arst_after got=%b/%b/%0d exp=0/0/0", issue, res_valid, count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_order();
        test_full_pop();
        test_flush();
        test_divz();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
